// File: rtl/fetch_pc.sv
// fetch_pc: program counter and instruction-fetch sequencer.
// Issues one outstanding instruction-memory request at a time, holds a
// single-entry instruction buffer for decode and squashes wrong-path
// fetches when the branch unit redirects.
// Optional feature macro: FETCH_MISALIGN_EN (sticky misaligned-target
// flag that halts fetch; without it target low bits are forced to zero).
module fetch_pc #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_taken,
   input  logic [31:0] redirect_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_EN
   ,
   output logic        fetch_misalign
`endif
);

   typedef enum logic {
      ST_REQ  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] req_pc_reg, req_pc_next;
   logic [31:0] buf_data_reg, buf_data_next;
   logic [31:0] buf_pc_reg, buf_pc_next;
   logic        buf_valid_reg, buf_valid_next;
   logic        drop_reg, drop_next;
   logic        inst_fire;
   logic        req_fire;
   logic        fetch_stop;
   logic [31:0] target_pc;

`ifdef FETCH_MISALIGN_EN
   logic misalign_reg, misalign_next;

   assign fetch_stop     = misalign_reg;
   assign target_pc      = redirect_target;
   assign fetch_misalign = misalign_reg;

   // Sticky misaligned-redirect flag; only reset clears it.
   always_comb begin
      misalign_next = misalign_reg;
      if (redirect_taken && (redirect_target[1:0] != 2'b00)) begin
         misalign_next = 1'b1;
      end
   end

   // Misalign flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_reg <= 1'b0;
      end else begin
         misalign_reg <= misalign_next;
      end
   end
`else
   assign fetch_stop = 1'b0;
   // Targets are always word aligned in this build.
   assign target_pc  = redirect_target & 32'hFFFF_FFFC;
`endif

   // Decode handshake: a redirect cycle never transfers an instruction.
   // Requests need room in the buffer (empty, or draining this cycle) and
   // are held off during reset so every output is quiet while rst_n is low.
   assign inst_valid     = buf_valid_reg & ~redirect_taken;
   assign inst_data      = buf_data_reg;
   assign inst_pc        = buf_pc_reg;
   assign inst_fire      = inst_valid & inst_ready;
   assign imem_req_valid = rst_n & ~fetch_stop & (state_reg == ST_REQ) &
                           (~buf_valid_reg | inst_fire) & ~redirect_taken;
   assign imem_req_addr  = pc_reg;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // Next-state logic: redirect overrides normal sequencing in any state.
   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      req_pc_next    = req_pc_reg;
      buf_data_next  = buf_data_reg;
      buf_pc_next    = buf_pc_reg;
      buf_valid_next = buf_valid_reg;
      drop_next      = drop_reg;
      if (redirect_taken) begin
         pc_next        = target_pc;
         buf_valid_next = 1'b0;
         if (state_reg == ST_WAIT) begin
            if (imem_rsp_valid) begin
               // Wrong-path response lands in the redirect cycle: discard it.
               drop_next  = 1'b0;
               state_next = ST_REQ;
            end else begin
               drop_next = 1'b1;
            end
         end
      end else begin
         if (inst_fire) begin
            buf_valid_next = 1'b0;
         end
         case (state_reg)
            ST_REQ: begin
               if (req_fire) begin
                  req_pc_next = pc_reg;
                  pc_next     = pc_reg + 32'd4;
                  state_next  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  state_next = ST_REQ;
                  if (drop_reg) begin
                     drop_next = 1'b0;
                  end else begin
                     // Load wins over a same-cycle drain.
                     buf_data_next  = imem_rsp_data;
                     buf_pc_next    = req_pc_reg;
                     buf_valid_next = 1'b1;
                  end
               end
            end
            default: state_next = ST_REQ;
         endcase
      end
   end

   // Sequencer state, PC and instruction buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_REQ;
         pc_reg        <= RESET_PC;
         req_pc_reg    <= RESET_PC;
         buf_data_reg  <= 32'd0;
         buf_pc_reg    <= 32'd0;
         buf_valid_reg <= 1'b0;
         drop_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         req_pc_reg    <= req_pc_next;
         buf_data_reg  <= buf_data_next;
         buf_pc_reg    <= buf_pc_next;
         buf_valid_reg <= buf_valid_next;
         drop_reg      <= drop_next;
      end
   end

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Program-counter and instruction-fetch sequencer; consumes the branch unit's resolved target/taken pair and steers fetch accordingly.
- Issues one-outstanding instruction-memory requests (valid/ready request, valid-only response).
- Holds a single-entry instruction buffer presented to decode with valid/ready.
- Squashes wrong-path fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- redirect_taken  input  1  branch/jump taken from the branch unit; level, one cycle per redirect.
- redirect_target  input  32  new PC when redirect_taken=1.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  fetch address (word aligned in normal operation).
- imem_rsp_valid  input  1  response data valid; exactly one per accepted request, at least 1 cycle after accept.
- imem_rsp_data  input  32  instruction word.
- inst_valid  output  1  buffered instruction valid to decode.
- inst_ready  input  1  decode accepts.
- inst_data  output  32  instruction word.
- inst_pc  output  32  address the instruction was fetched from.
- fetch_misalign  output  1  only with FETCH_MISALIGN_EN; see below.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - pc=RESET_PC, state=REQ, buf_valid=0, drop=0.
  - All outputs 0 except imem_req_addr=RESET_PC.
- Fire signals: inst_fire = inst_valid & inst_ready; req_fire = imem_req_valid & imem_req_ready.
- Combinational outputs:
  - inst_valid = buf_valid & ~redirect_taken. No decode transfer occurs in a redirect cycle.
  - imem_req_valid = (state==REQ) & (~buf_valid | inst_fire) & ~redirect_taken.
  - imem_req_addr = pc.
- State REQ:
  - On req_fire: req_pc<=pc, pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), go to WAIT.
  - Otherwise stay.
  - While pending, imem_req_addr changes only on redirect.
- State WAIT:
  - On imem_rsp_valid with drop=0: buf<=rsp_data, buf_pc<=req_pc, buf_valid<=1, go to REQ.
  - On imem_rsp_valid with drop=1: discard the data, drop<=0, go to REQ.
- Buffer: buf_valid clears on inst_fire unless reloaded in the same cycle (load wins).
- Redirect (redirect_taken=1), any state:
  - pc<=redirect_target and buf_valid<=0.
  - In REQ: no request issued this cycle; stay in REQ; the next cycle requests the target.
  - In WAIT without response this cycle: drop<=1, stay in WAIT.
  - In WAIT with response this cycle: discard the response, drop<=0, go to REQ.
  - Multiple redirects while dropping: drop stays 1; the latest target wins.
- Latency with memory responding 1 cycle after accept:
  - Accept at cycle N, response at N+1, inst_valid at N+2.
  - Steady-state throughput with inst_ready=1: one instruction per 2 cycles.
- Redirect-to-decode latency with ready memory: target request in cycle R+1, inst_valid with inst_pc=target at R+3.
- Reset asserted mid-operation: the state machine and buffer clear immediately; an in-flight memory response after reset is not guarded (memory is reset together).

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - A redirect whose redirect_target[1:0]!=0 sets sticky fetch_misalign=1, still clears the buffer and drops in-flight data, and then stops fetching (imem_req_valid stays 0).
  - Only reset clears the condition. Exception handling lives elsewhere.
- Undefined:
  - fetch_misalign port absent.
  - Target low bits are forced to 0 (pc<={redirect_target[31:2],2'b00}).

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1 -> requests at 0x0,0x4,0x8; decode receives inst_pc 0x0,0x4,0x8 with matching data; one per 2 cycles.
- inst_ready=0 for 5 cycles after the first instruction -> inst_valid held with stable data/pc; no new imem request while buffer is full; resumes with addr 0x4 on the ready cycle.
- Redirect to 0x100 while in WAIT, response at pc 0x8 arrives 3 cycles later -> response discarded; next request addr 0x100; decode never sees the 0x8 word.
- Redirect to 0x200 in the same cycle as a buffered instruction with inst_ready=1 -> inst_valid low that cycle, no transfer; next inst_pc=0x200.
- pc at 0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
- With FETCH_MISALIGN_EN, redirect to 0x102 -> fetch_misalign=1 next cycle, imem_req_valid stays 0; rst_n pulse clears it and fetch resumes at RESET_PC.
